// File: rtl/snn_pkg.sv
// Shared spiking-network definitions used by lif_neuron and the stdp weight-update block.
package snn_pkg;
  localparam int SPIKE_CNT_W = 16;
  localparam int W_WIDTH     = 8;

  typedef enum logic [1:0] {
    INTEGRATE  = 2'd0,
    FIRE       = 2'd1,
    REFRACTORY = 2'd2
  } lif_state_t;
endpackage

// File: rtl/leak_timer.sv
// Free-running leak period counter; advances only while run is high and wraps on tick.
module leak_timer #(
  parameter int LEAK_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  logic [7:0] r_cnt;

  assign tick = run && (r_cnt == 8'(LEAK_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      r_cnt <= 8'd0;
    else if (run)
      r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
  end
endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike integration, shift leak, fire and refractory hold.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int WIDTH       = W_WIDTH,
  parameter int THRESHOLD   = 200,
  parameter int LEAK_PERIOD = 16,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRACT     = 8,
  parameter int V_RESET     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pre_spike,
  input  logic [WIDTH-1:0]       weight,
  output logic                   post_spike,
  output logic [WIDTH-1:0]       membrane,
  output logic [1:0]             state,
  output logic [SPIKE_CNT_W-1:0] spike_count
);
  localparam int RW    = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam int RLOAD = (REFRACT > 0) ? REFRACT - 1 : 0;

  lif_state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]       r_membrane;
  logic [RW-1:0]          r_refr;
  logic [SPIKE_CNT_W-1:0] r_spike_count;

  logic             w_run, w_tick, w_fire;
  logic [WIDTH-1:0] w_shr, w_leak, w_vl, w_add;
  logic [WIDTH:0]   w_vc;

  assign w_run = (r_state == INTEGRATE) && enable;

  leak_timer #(.LEAK_PERIOD(LEAK_PERIOD)) u_leak (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clear (w_fire),
    .tick  (w_tick)
  );

  // Leak is at least 1 while nonzero, so small potentials still decay to 0.
  assign w_shr  = r_membrane >> LEAK_SHIFT;
  assign w_leak = (w_shr == '0 && r_membrane != '0) ? WIDTH'(1) : w_shr;
  assign w_vl   = w_tick ? r_membrane - w_leak : r_membrane;
  assign w_add  = pre_spike ? weight : '0;
  assign w_vc   = {1'b0, w_vl} + {1'b0, w_add};
  assign w_fire = w_run && (w_vc >= (WIDTH+1)'(THRESHOLD));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INTEGRATE:  if (w_fire) w_state_nxt = FIRE;
      FIRE:       w_state_nxt = (REFRACT == 0) ? INTEGRATE : REFRACTORY;
      REFRACTORY: if (r_refr == '0) w_state_nxt = INTEGRATE;
      default:    w_state_nxt = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= INTEGRATE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_membrane    <= WIDTH'(V_RESET);
      r_refr        <= '0;
      r_spike_count <= '0;
    end else begin
      case (r_state)
        INTEGRATE: begin
          if (w_run) r_membrane <= w_fire ? WIDTH'(V_RESET) : w_vc[WIDTH-1:0];
          if (w_fire && r_spike_count != '1)
            r_spike_count <= r_spike_count + SPIKE_CNT_W'(1);
        end
        FIRE: begin
          r_refr     <= RW'(RLOAD);
          r_membrane <= WIDTH'(V_RESET);
        end
        REFRACTORY: begin
          if (r_refr != '0) r_refr <= r_refr - RW'(1);
          r_membrane <= WIDTH'(V_RESET);
        end
        default: r_membrane <= r_membrane;
      endcase
    end
  end

  assign post_spike  = (r_state == FIRE);
  assign membrane    = r_membrane;
  assign state       = r_state;
  assign spike_count = r_spike_count;
endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: vector table plus hand sequences for leak, refractory, gating, reset, saturation.
module tb_lif_neuron;
  logic        clk = 1'b0;
  logic        reset, enable, pre_spike;
  logic [7:0]  weight;
  logic        post_spike;
  logic [7:0]  membrane;
  logic [1:0]  state;
  logic [15:0] spike_count;

  int n_tests = 0;
  int n_fail  = 0;

  lif_neuron dut (
    .clk(clk), .reset(reset), .enable(enable), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_spike), .membrane(membrane), .state(state), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        pre;
    logic [7:0]  w;
    logic [7:0]  mem;
    logic        post;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic pre, input logic [7:0] w);
    enable = en; pre_spike = pre; weight = w;
  endtask

  task automatic do_reset();
    reset = 1'b1; drive(1'b1, 1'b0, 8'd0);
    step(); step();
    reset = 1'b0;
  endtask

  // Leak staircase from 80: >>3 until it reaches 0, then 1 per tick, floor at 0.
  int leak_exp[30] = '{70, 62, 55, 49, 43, 38, 34, 30, 27, 24, 21, 19, 17, 15,
                       14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'd100, 8'd100, 1'b0, 2'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 8'd100, 8'd0,   1'b1, 2'd1, 16'd1};
    vecs[2]  = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 2'd2, 16'd1};
    for (int i = 3; i <= 9; i++)
      vecs[i] = '{1'b0, 1'b1, 8'd255, 8'd0, 1'b0, 2'd2, 16'd1};
    vecs[10] = '{1'b1, 1'b1, 8'd255, 8'd0,   1'b0, 2'd0, 16'd1};
    vecs[11] = '{1'b1, 1'b1, 8'd150, 8'd150, 1'b0, 2'd0, 16'd1};
    vecs[12] = '{1'b0, 1'b1, 8'd100, 8'd150, 1'b0, 2'd0, 16'd1};
    vecs[13] = '{1'b0, 1'b1, 8'd255, 8'd150, 1'b0, 2'd0, 16'd1};
    vecs[14] = '{1'b1, 1'b1, 8'd49,  8'd199, 1'b0, 2'd0, 16'd1};
    vecs[15] = '{1'b1, 1'b1, 8'd1,   8'd0,   1'b1, 2'd1, 16'd2};

    // Reset state
    do_reset();
    chk("rst_mem", membrane, 0);
    chk("rst_post", post_spike, 0);
    chk("rst_state", state, 0);
    chk("rst_cnt", spike_count, 0);

    // Table: integrate-and-fire, refractory pass, gating, exact threshold
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].pre, vecs[i].w);
      step();
      chk($sformatf("vec%0d_mem", i), membrane, vecs[i].mem);
      chk($sformatf("vec%0d_post", i), post_spike, vecs[i].post);
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_cnt", i), spike_count, vecs[i].cnt);
    end

    // Leak: one spike of 80, then idle through the ticks
    do_reset();
    drive(1'b1, 1'b1, 8'd80); step();
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 14; i++) step();
    chk("leak_pre_tick", membrane, 80);
    step();
    chk("leak_tick0", membrane, leak_exp[0]);
    for (int t = 1; t < 30; t++) begin
      for (int i = 0; i < 16; i++) step();
      chk($sformatf("leak_tick%0d", t), membrane, leak_exp[t]);
    end

    // Refractory: continuous max-weight spikes pulse every 10 cycles
    do_reset();
    drive(1'b1, 1'b1, 8'd255);
    for (int i = 1; i <= 40; i++) begin
      step();
      chk($sformatf("refr_post%0d", i), post_spike, ((i - 1) % 10 == 0) ? 1 : 0);
      if (state == 2'd2) chk($sformatf("refr_mem%0d", i), membrane, 0);
    end
    chk("refr_cnt", spike_count, 4);

    // Enable gating: hold with spikes while disabled, leak counter frozen
    do_reset();
    drive(1'b1, 1'b1, 8'd150); step();
    drive(1'b0, 1'b1, 8'd100);
    for (int i = 0; i < 40; i++) step();
    chk("gate_mem", membrane, 150);
    chk("gate_state", state, 0);
    chk("gate_cnt", spike_count, 0);
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 14; i++) step();
    chk("gate_frozen_mem", membrane, 150);
    drive(1'b1, 1'b1, 8'd100); step();
    chk("gate_fire_post", post_spike, 1);
    chk("gate_fire_mem", membrane, 0);

    // Reset in the third refractory cycle
    do_reset();
    drive(1'b1, 1'b1, 8'd200); step();
    chk("rr_fire", post_spike, 1);
    drive(1'b1, 1'b0, 8'd0);
    step(); step(); step();
    chk("rr_in_refr", state, 2);
    reset = 1'b1; step();
    chk("rr_state", state, 0);
    chk("rr_mem", membrane, 0);
    chk("rr_cnt", spike_count, 0);
    chk("rr_post", post_spike, 0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 8'd200); step();
    chk("rr_refire_post", post_spike, 1);
    chk("rr_refire_cnt", spike_count, 1);

    // Saturation from 0xFFFE over three fires
    do_reset();
    force dut.r_spike_count = 16'hFFFE;
    #1;
    release dut.r_spike_count;
    chk("sat_preload", spike_count, 16'hFFFE);
    drive(1'b1, 1'b1, 8'd255); step();
    chk("sat_fire1", spike_count, 16'hFFFF);
    for (int i = 0; i < 10; i++) step();
    chk("sat_fire2_post", post_spike, 1);
    chk("sat_fire2", spike_count, 16'hFFFF);
    for (int i = 0; i < 10; i++) step();
    chk("sat_fire3_post", post_spike, 1);
    chk("sat_fire3", spike_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that produces the post-synaptic spike train consumed by the `stdp` weight-update block. It integrates weighted pre-synaptic spikes into a membrane potential with periodic shift-based leak, fires a one-cycle `post_spike` on threshold crossing, then enforces a refractory window. Its `weight` input is driven by the STDP block's weight output, which closes the learning loop.

## Interface
- `WIDTH`, 8: membrane potential and weight width.
- `THRESHOLD`, 200: firing threshold; fire when the candidate potential is >= `THRESHOLD`.
- `LEAK_PERIOD`, 16: cycles between leak ticks; range 1..255.
- `LEAK_SHIFT`, 3: leak amount is `v >> LEAK_SHIFT`, with a minimum of 1 when `v != 0`.
- `REFRACT`, 8: refractory length in cycles; 0 is allowed.
- `V_RESET`, 0: membrane value loaded on fire; must be < `THRESHOLD`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: gates integration and leak in the INTEGRATE state.
- `pre_spike` in 1: pre-synaptic spike, sampled every cycle.
- `weight` in `WIDTH`: synaptic weight, unsigned, sampled together with `pre_spike`.
- `post_spike` out 1: high for exactly the one cycle spent in FIRE.
- `membrane` out `WIDTH`: registered membrane potential.
- `state` out 2: current FSM state encoding.
- `spike_count` out 16: number of fires, saturating at 0xFFFF.

## Operation
- FSM states: INTEGRATE=0, FIRE=1, REFRACTORY=2. Encoding 3 is unused and recovers to INTEGRATE on the next cycle.
- Reset values: state INTEGRATE, `membrane` = `V_RESET`, leak counter 0, refractory counter 0, `spike_count` 0, `post_spike` 0.
- INTEGRATE with `enable`=1, per cycle:
  - Leak tick is asserted when leak counter == `LEAK_PERIOD`-1. The counter wraps to 0 on the tick and otherwise increments.
  - `v_l` = v minus leak on a tick, otherwise v. Leak never underflows below 0.
  - `v_c` = `v_l` + (`pre_spike` ? `weight` : 0), computed in `WIDTH`+1 bits. No saturation is needed because the stored value is always < `THRESHOLD`.
  - If `v_c` >= `THRESHOLD`: next state FIRE, `membrane` <= `V_RESET`, leak counter <= 0, `spike_count` += 1 (saturating).
  - Otherwise `membrane` <= `v_c`.
- INTEGRATE with `enable`=0: membrane, leak counter and state all hold. `pre_spike` is ignored.
- FIRE: `post_spike`=1. Next state is REFRACTORY with refractory counter <= `REFRACT`-1, or INTEGRATE if `REFRACT`=0.
- REFRACTORY: `pre_spike` is ignored, there is no leak, and `membrane` holds `V_RESET`. The counter decrements each cycle; when it is 0, next state is INTEGRATE.
- FIRE and REFRACTORY proceed regardless of `enable`.
- `post_spike` is a Moore output (state == FIRE). It is never high on two consecutive cycles.

## Timing
- A `pre_spike` sampled at edge k that crosses threshold gives `post_spike`=1 during cycle k+1 (one-cycle latency) and `membrane`=`V_RESET` from edge k.
- Minimum inter-spike distance is 2+`REFRACT` cycles. The first input accepted after a fire is at the edge ending the last REFRACTORY cycle plus one.
- A spike arriving on a leak-tick cycle applies leak first, then the addition, in the same cycle.
- `reset` at any cycle, including in FIRE or REFRACTORY, has priority: all outputs return to reset values at the next edge, and `post_spike` drops after that edge.
- The `spike_count` increment coincides with the FIRE entry edge. At 0xFFFF it holds.

## Structure
- Shared package `snn_pkg`:
  - state enum `lif_state_t` (INTEGRATE/FIRE/REFRACTORY).
  - constants `SPIKE_CNT_W`=16 and `W_WIDTH`=8, shared with `stdp`.
- Sub-module `leak_timer`:
  - Parameter `LEAK_PERIOD`; inputs `clk`, `reset`, `run`, `clear`; output `tick`.
  - A counter that wraps on `tick`. `lif_neuron` drives `run` = INTEGRATE && `enable`, and `clear` = fire.
- The remaining datapath (leak subtract, widened add, compare) and the FSM stay in `lif_neuron`.

## Test plan
- Integrate-and-fire (default parameters):
  - Stimulus: reset; `enable`=1; `weight`=100 with `pre_spike` high on cycles 1 and 2 (no leak tick).
  - Required response: `membrane` 100, then 0; `post_spike` high for exactly one cycle, one cycle after the second spike; `spike_count`=1.
- Leak:
  - Stimulus: a single spike with `weight`=80, then idle.
  - Required response: `membrane` 80 until the first tick, then 70 (80−10), 62, 55, ... Each tick removes 1 once `v`>>3 reaches 0, ending at 0 with no underflow.
- Refractory:
  - Stimulus: after a fire, hold `pre_spike`=1 with `weight`=255 continuously.
  - Required response: `post_spike` pulses exactly every 10 cycles (FIRE + 8 REFRACTORY + 1 INTEGRATE); `membrane` stays 0 during REFRACTORY.
- Enable gating:
  - Stimulus: `membrane`=150, `enable`=0 for 40 cycles with spikes of `weight`=100.
  - Required response: `membrane` stays 150, no fire, leak counter frozen. Raising `enable` with a single spike fires.
- Reset mid-refractory:
  - Stimulus: assert `reset` in the 3rd REFRACTORY cycle.
  - Required response: next cycle state INTEGRATE, `membrane` 0, `spike_count` 0. A spike of 200 right after reset fires normally.
- Counter saturation:
  - Stimulus: force `spike_count` to 0xFFFE, then cause 3 fires.
  - Required response: `spike_count` reads 0xFFFF and holds.
